// File: rtl/cva6_ypb_obi_data_arb.sv
// ---------------------------------------------------------------------------
// cva6_ypb_obi_data_arb
//
// Purpose:
//   Merges the data-side YPB requesters of a cache-less pipeline onto one
//   in-order OBI data channel. It uses fixed priority, where index 0 wins:
//   0=mmu_ptw, 1=amo, 2=store, 3=load and 4=zcmt.
//   A request that is waiting for its grant locks the selection, so the OBI
//   attributes stay stable until the grant arrives.
//   Each accepted transaction records its source port and aid in a small
//   FIFO. OBI returns responses in order, so the FIFO head tells which port
//   owns each response.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   port_req_i/port_gnt_o   per-port request / grant (grant one-hot or zero)
//   port_addr_i, port_we_i, port_be_i, port_wdata_i, port_aid_i
//                           packed per-port request attributes
//   port_rvalid_o           per-port response valid (one-hot or zero)
//   port_rdata_o, port_rid_o, port_err_o
//                           response payload, shared by all ports
//   obi_req_o ... obi_wdata_o, obi_gnt_i
//                           OBI address/request phase
//   obi_rvalid_i, obi_rdata_i, obi_err_i
//                           OBI response phase, in order
//   outstanding_o           occupancy of the outstanding FIFO
//   unexpected_rsp_o        sticky flag: a response arrived with nothing
//                           outstanding
// ---------------------------------------------------------------------------
module cva6_ypb_obi_data_arb #(
    parameter int NR_PORTS        = 5,
    parameter int ADDR_W          = 64,
    parameter int DATA_W          = 64,
    parameter int ID_W            = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,

    input  logic [NR_PORTS-1:0]              port_req_i,
    output logic [NR_PORTS-1:0]              port_gnt_o,
    input  logic [NR_PORTS*ADDR_W-1:0]       port_addr_i,
    input  logic [NR_PORTS-1:0]              port_we_i,
    input  logic [NR_PORTS*DATA_W/8-1:0]     port_be_i,
    input  logic [NR_PORTS*DATA_W-1:0]       port_wdata_i,
    input  logic [NR_PORTS*ID_W-1:0]         port_aid_i,
    output logic [NR_PORTS-1:0]              port_rvalid_o,
    output logic [DATA_W-1:0]                port_rdata_o,
    output logic [ID_W-1:0]                  port_rid_o,
    output logic                             port_err_o,

    output logic                             obi_req_o,
    input  logic                             obi_gnt_i,
    output logic [ADDR_W-1:0]                obi_addr_o,
    output logic                             obi_we_o,
    output logic [DATA_W/8-1:0]              obi_be_o,
    output logic [DATA_W-1:0]                obi_wdata_o,
    input  logic                             obi_rvalid_i,
    input  logic [DATA_W-1:0]                obi_rdata_i,
    input  logic                             obi_err_i,

    output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
    output logic                             unexpected_rsp_o
);

    localparam int IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int BE_W  = DATA_W / 8;

    // ------------------------------------------------------------------
    // Per-port views of the packed attribute buses
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] addr_arr  [NR_PORTS];
    logic [BE_W-1:0]   be_arr    [NR_PORTS];
    logic [DATA_W-1:0] wdata_arr [NR_PORTS];
    logic [ID_W-1:0]   aid_arr   [NR_PORTS];

    genvar gi;
    generate
        for (gi = 0; gi < NR_PORTS; gi++) begin : g_unpack
            assign addr_arr[gi]  = port_addr_i[gi*ADDR_W +: ADDR_W];
            assign be_arr[gi]    = port_be_i[gi*BE_W +: BE_W];
            assign wdata_arr[gi] = port_wdata_i[gi*DATA_W +: DATA_W];
            assign aid_arr[gi]   = port_aid_i[gi*ID_W +: ID_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             unexpected_q, unexpected_d;

    // Outstanding FIFO storage. It is read combinationally because the
    // response has to be routed in the same cycle as obi_rvalid_i.
    logic [IDX_W-1:0] fifo_port_q [MAX_OUTSTANDING];
    logic [ID_W-1:0]  fifo_aid_q  [MAX_OUTSTANDING];

    // ------------------------------------------------------------------
    // Selection
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] prio_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_req;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Lowest-index requester wins. The loop runs downward so that the last
    // assignment made is the one for the lowest active index.
    always_comb begin
        prio_idx = '0;
        for (int i = NR_PORTS - 1; i >= 0; i--) begin
            if (port_req_i[i]) begin
                prio_idx = IDX_W'(i);
            end
        end
    end

    // While locked, the selection follows the held port only. If that port
    // drops its request, sel_req goes low, the OBI request deasserts and the
    // lock releases in the same cycle.
    assign sel_idx = lock_q ? lock_idx_q : prio_idx;
    assign sel_req = port_req_i[sel_idx];

    // Full looks only at the registered count, so a same-cycle pop cannot
    // create a path from obi_rvalid_i to obi_req_o.
    assign full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign empty = (cnt_q == '0);

    assign obi_req_o = sel_req & ~full;
    assign push      = obi_req_o & obi_gnt_i;
    assign pop       = obi_rvalid_i & ~empty;

    // Attributes are forced to zero when nothing is selected, so the bus is
    // quiet while no port is requesting.
    assign obi_addr_o  = sel_req ? addr_arr[sel_idx]  : '0;
    assign obi_we_o    = sel_req & port_we_i[sel_idx];
    assign obi_be_o    = sel_req ? be_arr[sel_idx]    : '0;
    assign obi_wdata_o = sel_req ? wdata_arr[sel_idx] : '0;

    // A request that is presented but not granted pins the selection.
    assign lock_d     = obi_req_o & ~obi_gnt_i;
    assign lock_idx_d = lock_d ? sel_idx : lock_idx_q;

    // ------------------------------------------------------------------
    // Grant and response fan-out
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] head_port;
    logic [ID_W-1:0]  head_aid;

    assign head_port = fifo_port_q[rd_ptr_q];
    assign head_aid  = fifo_aid_q[rd_ptr_q];

    generate
        for (gi = 0; gi < NR_PORTS; gi++) begin : g_fanout
            assign port_gnt_o[gi]    = push && (sel_idx == IDX_W'(gi));
            assign port_rvalid_o[gi] = pop && (head_port == IDX_W'(gi));
        end
    endgenerate

    assign port_rid_o   = pop ? head_aid : '0;
    assign port_rdata_o = pop ? obi_rdata_i : '0;
    assign port_err_o   = pop & obi_err_i;

    // ------------------------------------------------------------------
    // FIFO bookkeeping. The pointers are exactly PTR_W bits wide, so they
    // wrap on their own because the depth is a power of two.
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // A response with nothing outstanding has no owner. It is dropped and
    // the event is remembered until reset.
    assign unexpected_d = unexpected_q | (obi_rvalid_i & empty);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q       <= 1'b0;
            lock_idx_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            unexpected_q <= 1'b0;
        end else begin
            lock_q       <= lock_d;
            lock_idx_q   <= lock_idx_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            unexpected_q <= unexpected_d;
        end
    end

    // The storage needs no reset. An entry is only read after it has been
    // written, because pop requires a non-empty count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_port_q[wr_ptr_q] <= sel_idx;
            fifo_aid_q[wr_ptr_q]  <= aid_arr[sel_idx];
        end
    end

    assign outstanding_o    = cnt_q;
    assign unexpected_rsp_o = unexpected_q;

endmodule

// File: doc/cva6_ypb_obi_data_arb.md
Name: cva6_ypb_obi_data_arb

Overview:
- Downstream of the pipeline's data-side YPB ports (store, amo, load, mmu_ptw, zcmt) in the PipelineOnly (cache-less) configuration.
- Arbitrates these requesters onto one in-order OBI data channel toward the NoC.
- Records each granted transaction's source port and aid in an outstanding FIFO, then routes each OBI response back to the originating port with its aid.

Parameters:
- NR_PORTS, 5, number of YPB requesters; index 0 has highest priority (order: 0=mmu_ptw, 1=amo, 2=store, 3=load, 4=zcmt).
- ADDR_W, 64, address width.
- DATA_W, 64, data width (XLEN).
- ID_W, 2, YPB aid width.
- MAX_OUTSTANDING, 4, outstanding FIFO depth; power of two, at least 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- port_req_i  in  NR_PORTS  per-port request.
- port_gnt_o  out  NR_PORTS  per-port grant (one-hot or zero).
- port_addr_i  in  NR_PORTS*ADDR_W  packed addresses.
- port_we_i  in  NR_PORTS  write enable.
- port_be_i  in  NR_PORTS*DATA_W/8  byte enables.
- port_wdata_i  in  NR_PORTS*DATA_W  write data.
- port_aid_i  in  NR_PORTS*ID_W  transaction ids.
- port_rvalid_o  out  NR_PORTS  per-port response valid (one-hot or zero).
- port_rdata_o  out  DATA_W  response data, broadcast to all ports.
- port_rid_o  out  ID_W  aid of the returning response.
- port_err_o  out  1  response error.
- obi_req_o  out  1  OBI request.
- obi_gnt_i  in  1  OBI grant.
- obi_addr_o  out  ADDR_W.
- obi_we_o  out  1.
- obi_be_o  out  DATA_W/8.
- obi_wdata_o  out  DATA_W.
- obi_rvalid_i  in  1  OBI response valid (in order).
- obi_rdata_i  in  DATA_W.
- obi_err_i  in  1.
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current FIFO occupancy.
- unexpected_rsp_o  out  1  sticky: an rvalid arrived with the FIFO empty.

Behaviour:
- Reset (async, rst_ni=0):
  - FIFO empty, outstanding_o=0, unexpected_rsp_o=0, lock cleared.
  - All combinational outputs are 0 while no requests and no rvalid are present.
- Selection:
  - When unlocked, pick the lowest-index port with port_req_i=1.
  - When locked, reuse the registered locked index regardless of other requests.
- Lock:
  - Set when obi_req_o=1 and obi_gnt_i=0; store the selected index.
  - Cleared in the cycle obi_gnt_i=1.
  - This keeps OBI request attributes stable until grant.
  - If the locked port drops its req (protocol violation), the lock clears and obi_req_o deasserts that cycle.
- OBI request:
  - obi_req_o = selected port's req AND NOT full.
  - Address, we, be and wdata are muxed combinationally from the selected port.
  - Full means occupancy == MAX_OUTSTANDING.
  - A pop in the same cycle does NOT relieve full, so there is no rvalid-to-req combinational path.
- Grant:
  - port_gnt_o[sel] = obi_gnt_i AND obi_req_o; all other grant bits are 0.
  - On grant, push {sel, aid[sel]} into the FIFO; one transaction accepted per cycle at most.
- Response:
  - On obi_rvalid_i with the FIFO non-empty: pop the head.
  - Same cycle (zero latency): port_rvalid_o[head.port]=1, port_rid_o=head.aid, port_rdata_o=obi_rdata_i, port_err_o=obi_err_i.
- Push and pop in the same cycle: occupancy unchanged; pointers wrap modulo MAX_OUTSTANDING.
- rvalid while the FIFO is empty:
  - No port_rvalid_o is asserted and the FIFO is unchanged.
  - unexpected_rsp_o is set and stays 1 until reset.
- Latency: request path 0 cycles (combinational); response path 0 cycles.
- Reset mid-transaction: outstanding state is discarded; responses arriving after reset count as unexpected.

Test Plan:
- Single load: port3 req, addr 0x8000_0010, aid 1; gnt in the same cycle; rvalid 2 cycles later with rdata 0xDEAD_BEEF -> port_gnt_o=5'b01000, then port_rvalid_o=5'b01000 with rid 1 and rdata 0xDEAD_BEEF; outstanding_o goes 0->1->0.
- Priority and lock:
  - Setup: ports 3 and 4 request; gnt held low 3 cycles; port0 raises req in cycle 1.
  - Required: obi_addr_o stays port3's address all 3 cycles; port3 is granted first, then port0, then port4.
- Full:
  - Setup: 4 grants with no responses; port2 keeps requesting.
  - Required: obi_req_o=0 while outstanding_o=4, including a cycle with rvalid; obi_req_o returns to 1 the cycle after that pop.
- In-order routing: grant order port1 aid 2, port3 aid 0, port2 aid 3; three rvalids with err on the second -> port_rvalid_o = 00010, 01000, 00100; rids 2, 0, 3; port_err_o=1 only on the second.
- Wrap: 10 back-to-back transactions, each push alongside a pop -> outstanding_o stays 1; all responses route correctly across pointer wrap.
- Unexpected response: rvalid with the FIFO empty -> port_rvalid_o=0 and unexpected_rsp_o=1 until rst_ni is asserted low; asserting rst_ni low with 3 outstanding -> outstanding_o=0 immediately.
